// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : capture_pkg
// Purpose : Shared types and widths for the RGB444 camera capture block.
// Revision: 1.0 - initial release
// ============================================================================
package capture_pkg;

    localparam int PIX_W  = 12;
    localparam int BYTE_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        VSYNC      = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/capture.sv
`default_nettype none
// ============================================================================
// Module  : capture
// Purpose : Assembles RGB444 byte pairs from a camera bus into 12-bit FIFO writes.
// Revision: 1.0 - initial release
// ============================================================================
module capture
    import capture_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_full,
    output logic              o_wr,
    output logic [PIX_W-1:0]  o_wdata,
    output logic              o_sof
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_phase;
    logic               w_phase_nxt;
    logic [NIB_W-1:0]   r_red;
    logic [NIB_W-1:0]   w_red_nxt;
    logic               r_wr;
    logic               w_wr_nxt;
    logic [PIX_W-1:0]   r_wdata;
    logic [PIX_W-1:0]   w_wdata_nxt;
    logic               r_sof;
    logic               w_sof_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= WAIT_FRAME;
            r_phase <= 1'b0;
            r_red   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_sof   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_red   <= w_red_nxt;
            r_wr    <= w_wr_nxt;
            r_wdata <= w_wdata_nxt;
            r_sof   <= w_sof_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_red_nxt   = r_red;
        w_wr_nxt    = 1'b0;
        w_wdata_nxt = r_wdata;
        w_sof_nxt   = 1'b0;

        case (r_state)
            WAIT_FRAME: begin
                w_phase_nxt = 1'b0;
                if (i_vsync) begin
                    w_state_nxt = VSYNC;
                end
            end
            VSYNC: begin
                w_phase_nxt = 1'b0;
                if (!i_vsync) begin
                    w_state_nxt = ACTIVE;
                    w_sof_nxt   = 1'b1;
                end
            end
            ACTIVE: begin
                if (i_vsync) begin
                    // A new frame sync abandons any half-received pixel.
                    w_state_nxt = VSYNC;
                    w_phase_nxt = 1'b0;
                end else if (!i_href) begin
                    w_phase_nxt = 1'b0;
                end else if (!r_phase) begin
                    w_red_nxt   = i_data[NIB_W-1:0];
                    w_phase_nxt = 1'b1;
                end else begin
                    // Pixel completes here; a full FIFO drops it without stalling.
                    w_phase_nxt = 1'b0;
                    if (!i_full) begin
                        w_wr_nxt    = 1'b1;
                        w_wdata_nxt = {r_red, i_data};
                    end
                end
            end
            default: begin
                w_state_nxt = WAIT_FRAME;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    assign o_wr    = r_wr;
    assign o_wdata = r_wdata;
    assign o_sof   = r_sof;

endmodule
`default_nettype wire

// File: tb/tb_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_capture
// Purpose : Self-checking bench for capture against a frame/byte-count model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_capture;
    import capture_pkg::*;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        full;
    logic        wr;
    logic [11:0] wdata;
    logic        sof;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    logic [11:0] got [$];
    logic [11:0] exp_q [$];
    int          sof_cnt = 0;
    int          sof_cyc = 0;
    int          wr_cyc = 0;
    bq_t         q;

    always #5 clk = ~clk;

    capture dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_vsync (vsync),
        .i_href  (href),
        .i_data  (data),
        .i_full  (full),
        .o_wr    (wr),
        .o_wdata (wdata),
        .o_sof   (sof)
    );

    // Reference: frame armed after a vsync high->low; pixels pair bytes by count within an href run.
    bit          m_in_vsync = 1'b0;
    bit          m_in_frame = 1'b0;
    int          m_cnt = 0;
    logic [7:0]  m_first = 8'h00;
    logic        m_wr = 1'b0;
    logic        m_sof = 1'b0;
    logic [11:0] m_wdata = 12'h000;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_in_vsync <= 1'b0;
            m_in_frame <= 1'b0;
            m_cnt      <= 0;
            m_wr       <= 1'b0;
            m_sof      <= 1'b0;
            m_wdata    <= 12'h000;
        end else begin
            m_wr  <= 1'b0;
            m_sof <= 1'b0;
            if (vsync) begin
                m_in_vsync <= 1'b1;
                m_in_frame <= 1'b0;
                m_cnt      <= 0;
            end else if (m_in_vsync) begin
                m_in_vsync <= 1'b0;
                m_in_frame <= 1'b1;
                m_sof      <= 1'b1;
                m_cnt      <= 0;
            end else if (m_in_frame && href) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt % 2 == 0) begin
                    m_first <= data;
                end else if (!full) begin
                    m_wr    <= 1'b1;
                    m_wdata <= {m_first[3:0], data};
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("o_wr", {31'd0, wr}, {31'd0, m_wr});
            check("o_sof", {31'd0, sof}, {31'd0, m_sof});
            check("o_wdata", {20'd0, wdata}, {20'd0, m_wdata});
            if (wr === 1'b1) begin
                got.push_back(wdata);
                wr_cyc = cyc;
            end
            if (sof === 1'b1) begin
                sof_cnt++;
                sof_cyc = cyc;
            end
        end
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d, input logic f);
        vsync = v;
        href  = h;
        data  = d;
        full  = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic vsync_seq(input int n);
        repeat (n) drive(1'b1, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0);
        drive(1'b0, 1'b0, 8'($urandom), 1'b0);
        idle(1);
    endtask

    task automatic row(input bq_t b, input logic f);
        foreach (b[i]) drive(1'b0, 1'b1, b[i], f);
        drive(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'h00;
        full  = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        check("reset_wr", {31'd0, wr}, 32'd0);
        check("reset_wdata", {20'd0, wdata}, 32'd0);
        check("reset_sof", {31'd0, sof}, 32'd0);
        rst = 1'b0;

        // Href traffic before any vsync must be ignored.
        q = {8'h12, 8'h34, 8'h56, 8'h78};
        row(q, 1'b0);
        idle(2);
        check("pre_vsync_writes", got.size(), 32'd0);
        check("pre_vsync_sof", sof_cnt, 32'd0);

        // Basic pixel F3,A5 -> 0x3A5 after one sof.
        vsync_seq(3);
        q = {8'hF3, 8'hA5};
        row(q, 1'b0);
        idle(2);
        check("basic_count", got.size(), 32'd1);
        if (got.size() > 0) check("basic_pixel", {20'd0, got[0]}, 32'h3A5);
        check("basic_sof_count", sof_cnt, 32'd1);
        check("sof_before_wr", {31'd0, sof_cyc < wr_cyc}, 32'd1);

        // Trailing odd byte dropped; next row restarts at phase 0.
        got.delete();
        q = {8'h01, 8'h23, 8'h45};
        row(q, 1'b0);
        q = {8'h67, 8'h89};
        row(q, 1'b0);
        idle(1);
        check("odd_count", got.size(), 32'd2);
        if (got.size() > 1) begin
            check("odd_pixel0", {20'd0, got[0]}, 32'h123);
            check("odd_pixel1", {20'd0, got[1]}, 32'h789);
        end

        // FIFO full drops pixels; recovery after deassert.
        got.delete();
        q = {8'h0C, 8'hDE, 8'h0F, 8'h12};
        row(q, 1'b1);
        check("full_count", got.size(), 32'd0);
        q = {8'h01, 8'hAB};
        row(q, 1'b0);
        idle(1);
        check("after_full_count", got.size(), 32'd1);
        if (got.size() > 0) check("after_full_pixel", {20'd0, got[0]}, 32'h1AB);

        // Reset mid-pixel: no write of 0x7xx, waits for the next vsync.
        got.delete();
        drive(1'b0, 1'b1, 8'h07, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h99, 1'b0);
        check("midrst_wr", {31'd0, wr}, 32'd0);
        check("midrst_wdata", {20'd0, wdata}, 32'd0);
        check("midrst_sof", {31'd0, sof}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h88, 1'b0);
        q = {8'h55, 8'h66};
        row(q, 1'b0);
        check("midrst_no_write", got.size(), 32'd0);
        vsync_seq(2);
        q = {8'h0B, 8'hCD};
        row(q, 1'b0);
        idle(1);
        check("midrst_resume_count", got.size(), 32'd1);
        if (got.size() > 0) check("midrst_resume_pixel", {20'd0, got[0]}, 32'hBCD);

        // 5 frames x 5 rows x 10 random bytes, expectations built from the sent bytes.
        got.delete();
        exp_q.delete();
        for (int f = 0; f < 5; f++) begin
            vsync_seq($urandom_range(1, 3));
            for (int r = 0; r < 5; r++) begin
                q.delete();
                for (int b = 0; b < 10; b++) q.push_back(8'($urandom));
                for (int p = 0; p < 5; p++) exp_q.push_back({q[2*p][3:0], q[2*p+1]});
                row(q, 1'b0);
                idle($urandom_range(0, 2));
            end
        end
        idle(1);
        check("bulk_count", got.size(), 32'd125);
        foreach (exp_q[i]) begin
            if (i < got.size()) check("bulk_pixel", {20'd0, got[i]}, {20'd0, exp_q[i]});
        end

        // Unconstrained random traffic, checked cycle-by-cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
                  8'($urandom), $urandom_range(0, 4) == 0);
        end
        rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
